avalon_mem_responder: RTL and testbench
=======================================

# avalon_mem_responder

Avalon-MM memory responder on the memory side of the Sobel bus wrapper's master port. Answers the master's pixel-word reads with fixed-latency pipelined read data and stores written output pixels. Clears itself after reset and offers a side preload port so benches and the host can load an image before `start`. Serves as both the system-level frame memory model and the synthesizable on-chip pixel buffer.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words (power of two, ≥4).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0 (word-aligned).
- `READ_LATENCY`, 2: cycles from accepted read to `readdatavalid` (1–4).
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: reset, synchronous, active-low.
- `read` in 1: bus read request.
- `write` in 1: bus write request.
- `address` in 32: byte address.
- `writedata` in 32: write data.
- `byteenable` in 4: per-byte write mask; bit i ↔ bits 8i+7:8i.
- `readdata` out 32: read data, valid only with `readdatavalid`, else 0.
- `readdatavalid` out 1: one-cycle pulse per accepted read.
- `waitrequest` out 1: request not accepted this cycle.
- `load_en` in 1: preload write strobe.
- `load_addr` in log2(DEPTH): preload word index.
- `load_data` in 32: preload data, full word.
- `init_done` out 1: clear finished, bus usable.
- `err` out 1: sticky protocol/range error.

## Operation
- FSM states:
  - INIT: a `log2(DEPTH)`-bit counter writes 0 to word 0..DEPTH-1, one word per cycle. Moves to READY after word DEPTH-1.
  - READY: serves the bus and the load port.
- Reset (`n_rst`=0 at edge):
  - Enter INIT, counter=0.
  - Flush read pipeline. In-flight reads never produce `readdatavalid`.
  - `err`=0.
  - Applies mid-operation too. Memory is re-cleared.
- In INIT: `waitrequest`=1, `init_done`=0. `load_en` and bus requests are ignored and do not set `err`.
- Decode: `idx = (address - BASE_ADDR) >> 2`. In range iff `address` ≥ `BASE_ADDR`, `idx` < DEPTH and `address[1:0]`=0.
- Acceptance in READY:
  - `waitrequest` = `load_en`, so the load port has priority.
  - A request is accepted when `(read|write) & !waitrequest`.
- Accepted write:
  - In range: bytes with `byteenable`=1 are updated at that edge.
  - Out of range: dropped, `err` set.
- Accepted read:
  - Enters the latency pipeline carrying the data sampled from the array at the accept edge.
  - Out of range: carries 32'hDEAD_BEEF and sets `err`.
  - One read is accepted per cycle, so up to READ_LATENCY are outstanding, returned in order.
- `read`=`write`=1 together (accepted): the write is performed, the read is dropped (no `readdatavalid`), and `err` is set.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data. A same-cycle pair is the violation above.
- `load_en` in READY writes `load_data` to `load_addr` (all bytes) at the edge.
- `err` clears only on reset.

## Timing
- Reset values: `readdata`=0, `readdatavalid`=0, `waitrequest`=1, `init_done`=0, `err`=0.
- INIT lasts exactly DEPTH cycles.
  - The first edge after reset release writes word 0.
  - `init_done` and `waitrequest`=0 appear the cycle after word DEPTH-1 is cleared, unless `load_en`=1.
- Read accepted at edge N: `readdatavalid`=1 and `readdata` valid during the cycle after edge N+READ_LATENCY-1. With latency 2, valid in cycle N+2, counting the request cycle as N.
- Back-to-back reads give back-to-back `readdatavalid` pulses, with no bubbles.
- Write accepted at edge N is visible to any read accepted at edge ≥N+1.
- `waitrequest` is combinational from `load_en` and state. The requester holds `read`/`write`/`address` stable while `waitrequest`=1.
- `err` rises the cycle after the offending accept edge.

## Structure
- Shared package `avalon_pkg`:
  - State enum `mem_state_t` {INIT, READY}.
  - Constant `AV_BAD_READ = 32'hDEAD_BEEF`.
  - Byte-lane merge function `be_merge(old, new, be)`.
- One sub-module `avalon_rd_pipe`: a READ_LATENCY-deep valid/data shift register with synchronous flush.
- The memory array and FSM live in the top.

## Test plan
1. Reset, DEPTH=16 → `waitrequest`=1 for 16 cycles, then `init_done`=1. A read of 0x0 then returns 0 with `readdatavalid` two cycles after accept.
2. Preload words 0..3 = 0x11,0x22,0x33,0x44 via `load_en`, then read 0x0,0x4,0x8,0xC on consecutive cycles → four consecutive `readdatavalid` pulses returning 0x11,0x22,0x33,0x44 in order.
3. Word 5 = 0xAABBCCDD, write 0x0000_00EE with `byteenable`=4'b0001 to 0x14, read 0x14 next cycle → 0xAABBCCEE.
4. Read 0x40 (idx 16, DEPTH=16) and read 0x2 → each returns 0xDEADBEEF with `readdatavalid`. `err`=1 and stays 1.
5. Hold `read` with `load_en`=1 for 3 cycles → `waitrequest`=1, no read accepted. The read is accepted the cycle `load_en` drops.
6. Issue 2 reads, assert `n_rst`=0 the next cycle → no `readdatavalid` afterward. The FSM re-enters INIT, and preloaded words read back 0 after `init_done`.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared types, constants and helpers for the Avalon-MM memory responder.
package avalon_pkg;

  localparam int unsigned AV_DATA_W = 32;
  localparam int unsigned AV_BE_W   = 4;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_t;

  // Returned for reads that miss the array.
  localparam logic [AV_DATA_W-1:0] AV_BAD_READ = 32'hDEAD_BEEF;

  // Replace the byte lanes of old_word selected by be with those of new_word.
  function automatic logic [AV_DATA_W-1:0] be_merge(
    input logic [AV_DATA_W-1:0] old_word,
    input logic [AV_DATA_W-1:0] new_word,
    input logic [AV_BE_W-1:0]   be
  );
    logic [AV_DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(AV_BE_W); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_rd_pipe.sv
// Fixed-latency read return pipeline: valid/data shift register with flush.
module avalon_rd_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];

  // Shift read responses towards the output; data lanes stay zero when idle.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld <= '0;
      for (int i = 0; i < int'(LAT); i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < int'(LAT); i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: self-clearing word array, preload port and
// fixed-latency pipelined reads.
module avalon_mem_responder
  import avalon_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              address,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  output logic                     readdatavalid,
  output logic                     waitrequest,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     init_done,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);

  mem_state_t       state;
  mem_state_t       state_next;
  logic [AW-1:0]    clr_cnt;
  logic [31:0]      mem [DEPTH];

  logic [31:0]      addr_off;
  logic [AW-1:0]    idx;
  logic             in_range;
  logic             accept;
  logic             wr_acc;
  logic             rd_acc;
  logic             err_set;

  logic             mem_we;
  logic [AW-1:0]    mem_widx;
  logic [31:0]      mem_wdata;
  logic [31:0]      rd_word;
  logic             pipe_flush;

  // Byte address to word index and range check.
  always_comb begin
    addr_off = address - BASE_ADDR;
    idx      = addr_off[AW+1:2];
    in_range = (address >= BASE_ADDR) &&
               (addr_off[31:AW+2] == '0) &&
               (addr_off[1:0] == 2'b00);
  end

  // FSM state register, clear counter and init_done flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state_next == READY);
      if (state == INIT) clr_cnt <= clr_cnt + AW'(1);
    end
  end

  // Leave INIT once the last word has been cleared.
  always_comb begin
    state_next = state;
    if ((state == INIT) && (clr_cnt == AW'(DEPTH - 1))) state_next = READY;
  end

  // Bus handshake and acceptance; the load port stalls the bus.
  always_comb begin
    waitrequest = 1'b1;
    accept      = 1'b0;
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    err_set     = 1'b0;
    if (state == READY) begin
      waitrequest = load_en;
      accept      = (read | write) & ~load_en;
      wr_acc      = accept & write;
      rd_acc      = accept & read & ~write;
      err_set     = accept & ((write & ~in_range) | (read & write) |
                              (read & ~write & ~in_range));
    end
  end

  // Single array write port: clear, preload, then bus write.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = clr_cnt;
    mem_wdata = '0;
    if (state == INIT) begin
      mem_we = 1'b1;
    end else if (load_en) begin
      mem_we    = 1'b1;
      mem_widx  = load_addr;
      mem_wdata = load_data;
    end else if (wr_acc && in_range) begin
      mem_we    = 1'b1;
      mem_widx  = idx;
      mem_wdata = be_merge(mem[idx], writedata, byteenable);
    end
  end

  // Word array; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (n_rst && mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Sticky error flag.
  always_ff @(posedge clk) begin
    if (!n_rst)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Data captured at the accept edge, before any same-edge update.
  always_comb begin
    rd_word    = in_range ? mem[idx] : AV_BAD_READ;
    pipe_flush = ~n_rst;
  end

  avalon_rd_pipe #(
    .LAT (READ_LATENCY),
    .W   (32)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (pipe_flush),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Self-checking bench for avalon_mem_responder (DEPTH=16, latency 2).
module tb_avalon_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        read, write, load_en;
  logic [31:0] address, writedata, load_data, readdata;
  logic [3:0]  byteenable, load_addr;
  logic        readdatavalid, waitrequest, init_done, err;

  avalon_mem_responder #(
    .DEPTH        (DEPTH),
    .BASE_ADDR    (32'h0000_0000),
    .READ_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .init_done     (init_done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        n_rst;
    logic        rd;
    logic        wr;
    logic        ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  laddr;
    logic [31:0] ldata;
  } in_t;

  typedef struct {
    in_t         in;
    logic        ew;
    logic        erdv;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  resp_t       q [$];
  int          cyc = 0;
  int          init_left = 0;
  bit          known = 0;
  logic        err_m = 1'b0;

  // Outputs sampled in the most recent cycle
  logic        s_wait, s_rdv, s_done, s_err;
  logic [31:0] s_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic in_t idle_in();
    in_t v;
    v.n_rst = 1'b1; v.rd = 1'b0; v.wr = 1'b0; v.ld = 1'b0;
    v.addr = '0; v.wdata = '0; v.be = '0; v.laddr = '0; v.ldata = '0;
    return v;
  endfunction

  function automatic in_t rd_in(input logic [31:0] a);
    in_t v;
    v = idle_in();
    v.rd = 1'b1; v.addr = a;
    return v;
  endfunction

  function automatic in_t ld_in(input logic [3:0] la, input logic [31:0] ld);
    in_t v;
    v = idle_in();
    v.ld = 1'b1; v.laddr = la; v.ldata = ld;
    return v;
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  // One bus cycle: drive, check against the model, clock, advance the model.
  task automatic do_cycle(input in_t v);
    logic exp_rdv;
    logic [31:0] exp_rd, w;
    n_rst = v.n_rst; read = v.rd; write = v.wr; load_en = v.ld;
    address = v.addr; writedata = v.wdata; byteenable = v.be;
    load_addr = v.laddr; load_data = v.ldata;
    #1;
    s_wait = waitrequest; s_rdv = readdatavalid; s_rd = readdata;
    s_done = init_done; s_err = err;
    if (known) begin
      exp_rdv = (q.size() > 0) && (q[0].due == cyc);
      exp_rd  = exp_rdv ? q[0].data : 32'h0;
      if (exp_rdv) void'(q.pop_front());
      chk("waitrequest", 32'(s_wait), 32'(init_left != 0 || v.ld));
      chk("init_done", 32'(s_done), 32'(init_left == 0));
      chk("readdatavalid", 32'(s_rdv), 32'(exp_rdv));
      chk("readdata", s_rd, exp_rd);
      chk("err", 32'(s_err), 32'(err_m));
    end
    @(posedge clk);
    cyc++;
    if (!v.n_rst) begin
      known = 1; init_left = DEPTH; q.delete(); err_m = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = '0;
    end else if (known) begin
      if (init_left > 0) init_left--;
      else if (v.ld) mem_m[v.laddr] = v.ldata;
      else if (v.wr) begin
        if (v.rd) err_m = 1'b1;
        if (in_rng(v.addr)) begin
          w = mem_m[v.addr / 4];
          for (int b = 0; b < 4; b++)
            if (v.be[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
          mem_m[v.addr / 4] = w;
        end else err_m = 1'b1;
      end else if (v.rd) begin
        if (in_rng(v.addr)) q.push_back('{data: mem_m[v.addr / 4], due: cyc + LAT - 1});
        else begin
          q.push_back('{data: 32'hDEAD_BEEF, due: cyc + LAT - 1});
          err_m = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input in_t i, input logic ew, input logic erdv,
                              input logic [31:0] erd, input logic eerr);
    vec_t r;
    r.in = i; r.ew = ew; r.erdv = erdv; r.erd = erd; r.eerr = eerr;
    return r;
  endfunction

  vec_t tbl [$];
  in_t  t;
  int   pulses;

  initial begin
    n_rst = 1'b0; read = 1'b0; write = 1'b0; load_en = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    load_addr = '0; load_data = '0;
    @(negedge clk);

    // Reset, then INIT holds waitrequest for exactly DEPTH cycles.
    t = idle_in(); t.n_rst = 1'b0;
    do_cycle(t);
    do_cycle(t);
    chk("reset_readdatavalid", 32'(s_rdv), 32'h0);
    chk("reset_readdata", s_rd, 32'h0);
    chk("reset_err", 32'(s_err), 32'h0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      do_cycle(idle_in());
      chk("init_waitrequest", 32'(s_wait), 32'h1);
      chk("init_done_low", 32'(s_done), 32'h0);
    end
    do_cycle(rd_in(32'h0));
    chk("init_done_high", 32'(s_done), 32'h1);
    chk("ready_waitrequest", 32'(s_wait), 32'h0);
    do_cycle(idle_in());
    do_cycle(idle_in());
    chk("first_read_valid", 32'(s_rdv), 32'h1);
    chk("first_read_data", s_rd, 32'h0);
    do_cycle(idle_in());

    // Directed table: preload/burst read, byte write, range errors, load stall.
    tbl.push_back(mk(ld_in(4'd0, 32'h11), 1, 0, 32'h0, 0));
    tbl.push_back(mk(ld_in(4'd1, 32'h22), 1, 0, 32'h0, 0));
    tbl.push_back(mk(ld_in(4'd2, 32'h33), 1, 0, 32'h0, 0));
    tbl.push_back(mk(ld_in(4'd3, 32'h44), 1, 0, 32'h0, 0));
    tbl.push_back(mk(rd_in(32'h0), 0, 0, 32'h0, 0));
    tbl.push_back(mk(rd_in(32'h4), 0, 0, 32'h0, 0));
    tbl.push_back(mk(rd_in(32'h8), 0, 1, 32'h11, 0));
    tbl.push_back(mk(rd_in(32'hC), 0, 1, 32'h22, 0));
    tbl.push_back(mk(idle_in(), 0, 1, 32'h33, 0));
    tbl.push_back(mk(idle_in(), 0, 1, 32'h44, 0));
    tbl.push_back(mk(ld_in(4'd5, 32'hAABB_CCDD), 1, 0, 32'h0, 0));
    t = idle_in(); t.wr = 1'b1; t.addr = 32'h14; t.wdata = 32'h0000_00EE; t.be = 4'b0001;
    tbl.push_back(mk(t, 0, 0, 32'h0, 0));
    tbl.push_back(mk(rd_in(32'h14), 0, 0, 32'h0, 0));
    tbl.push_back(mk(idle_in(), 0, 0, 32'h0, 0));
    tbl.push_back(mk(idle_in(), 0, 1, 32'hAABB_CCEE, 0));
    tbl.push_back(mk(rd_in(32'h40), 0, 0, 32'h0, 0));
    tbl.push_back(mk(rd_in(32'h2), 0, 0, 32'h0, 1));
    tbl.push_back(mk(idle_in(), 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk(idle_in(), 0, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk(idle_in(), 0, 0, 32'h0, 1));
    t = ld_in(4'd0, 32'h11); t.rd = 1'b1; t.addr = 32'h0;
    tbl.push_back(mk(t, 1, 0, 32'h0, 1));
    tbl.push_back(mk(t, 1, 0, 32'h0, 1));
    tbl.push_back(mk(t, 1, 0, 32'h0, 1));
    tbl.push_back(mk(rd_in(32'h0), 0, 0, 32'h0, 1));
    tbl.push_back(mk(idle_in(), 0, 0, 32'h0, 1));
    tbl.push_back(mk(idle_in(), 0, 1, 32'h11, 1));
    tbl.push_back(mk(idle_in(), 0, 0, 32'h0, 1));
    foreach (tbl[i]) begin
      do_cycle(tbl[i].in);
      chk($sformatf("tbl%0d_wait", i), 32'(s_wait), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d_rdv", i), 32'(s_rdv), 32'(tbl[i].erdv));
      chk($sformatf("tbl%0d_rdata", i), s_rd, tbl[i].erd);
      chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].eerr));
    end

    // Reset with reads in flight: later reads are flushed, memory re-cleared.
    do_cycle(ld_in(4'd1, 32'h55));
    do_cycle(rd_in(32'h0));
    do_cycle(rd_in(32'h4));
    t = idle_in(); t.n_rst = 1'b0;
    do_cycle(t);
    chk("pre_reset_return", s_rd, 32'h11);
    pulses = 0;
    for (int i = 0; i < int'(DEPTH) + 4; i++) begin
      do_cycle(idle_in());
      if (s_rdv) pulses++;
    end
    chk("flushed_pulses", 32'(pulses), 32'h0);
    chk("err_cleared", 32'(s_err), 32'h0);
    do_cycle(rd_in(32'h4));
    do_cycle(idle_in());
    do_cycle(idle_in());
    chk("recleared_valid", 32'(s_rdv), 32'h1);
    chk("recleared_data", s_rd, 32'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      t = idle_in();
      t.n_rst = ($urandom_range(0, 299) != 0);
      t.ld    = ($urandom_range(0, 5) == 0);
      t.rd    = ($urandom_range(0, 1) == 1);
      t.wr    = ($urandom_range(0, 2) == 0);
      if (t.rd && t.wr && $urandom_range(0, 3) != 0) t.wr = 1'b0;
      t.addr  = 32'($urandom_range(0, 20)) * 4;
      if ($urandom_range(0, 9) == 0) t.addr = t.addr + 32'($urandom_range(1, 3));
      t.wdata = $urandom;
      t.be    = 4'($urandom_range(0, 15));
      t.laddr = 4'($urandom_range(0, 15));
      t.ldata = $urandom;
      do_cycle(t);
    end
    for (int i = 0; i < 4; i++) do_cycle(idle_in());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
